clk_div_prog: RTL and testbench
===============================

Name: clk_div_prog

Overview:
- Runtime-programmable integer clock divider; successor to the fixed odd-ratio divider.
- Generates a 50%-duty divided clock for any ratio N in 2..2^CNT_W-1, odd or even, from a single source clock.
- Ratio changes are applied glitch-free at period boundaries; adds enable, load handshake and a phase tick for downstream logic in the clk domain.

Parameters:
- CNT_W, 8, width of ratio and period counter.
- DEF_DIV, 7, ratio after reset; must be in 2..2^CNT_W-1.

Ports:
- clk  in  1  source clock; posedge logic, plus one negedge flop for odd ratios.
- rst  in  1  reset, synchronous to clk, active-high.
- en  in  1  divider enable.
- div_val  in  CNT_W  requested ratio N.
- div_load  in  1  single-cycle strobe; captures div_val.
- div_busy  out  1  a captured ratio is pending and not yet applied.
- div_err  out  1  one-cycle pulse when div_load carries div_val < 2.
- div_cur  out  CNT_W  ratio currently in effect.
- clk_out  out  1  divided clock.
- tick  out  1  one-clk pulse in the cycle clk_out rises, posedge domain.

Behaviour:
- Reset (rst high at posedge):
  - div_cur=DEF_DIV; cnt=div_cur-1; div_p=0; tick=0; div_busy=0; div_err=0; pending cleared.
  - div_n clears at the first negedge that samples rst high.
  - clk_out=0. rst has priority over every other input.
- Counter (posedge, en=1): cnt_next = (cnt==div_cur-1) ? 0 : cnt+1. H = floor(div_cur/2).
  - div_p <= (cnt_next < H).
  - tick <= (cnt_next == 0).
- Negedge flop: div_n <= div_p, giving a copy of div_p delayed by half a clk period.
- Output:
  - Even N: clk_out = div_p.
  - Odd N: clk_out = div_p | div_n.
  - Odd result: high for N/2 clk periods (the 0.5 comes from the negedge extension), low for the remainder.
- Latency:
  - clk_out rises at the first posedge with en=1 after reset or after re-enable.
  - tick is high for that cycle.
- Period: exactly div_cur clk cycles between successive tick pulses while en=1 and no ratio change is applied.
- en=0:
  - cnt <= div_cur-1; div_p <= 0; tick <= 0.
  - clk_out parks low within 1 clk.
  - A truncated high phase is permitted; minimum pulse width is 0.5 clk.
  - Re-enable restarts at phase 0.
- Load handshake:
  - div_load=1 with div_val>=2: pending <= div_val; div_busy <= 1.
  - div_load while div_busy=1: overwrites pending; last write wins.
  - div_load with div_val<2: div_err=1 next cycle; pending and div_busy unchanged.
- Apply:
  - Applied at a posedge where div_busy=1 and either (en=1 and cnt==div_cur-1) or en=0.
  - On apply: div_cur <= pending; div_busy <= 0; cnt_next=0, with the new H used for div_p.
  - The new ratio's first period starts with that posedge's tick.
- Simultaneous load and apply in the same cycle:
  - The previously pending value is applied.
  - The new value becomes pending; div_busy stays 1 and applies at the next boundary.
- Odd-to-even switch: div_n may still be high for 0.5 clk after the boundary. clk_out is forced to div_p by the new even flag, so no extra pulse occurs.
- Reset mid-period: clk_out low after at most 1 clk; the pending ratio is discarded.
- Arithmetic:
  - All compares are unsigned CNT_W bits.
  - Maximum N = 2^CNT_W-1, so cnt never overflows.
  - No truncation in div_cur-1 because div_cur>=2.

Test Plan:
1. Release rst, en=1, default N=7 -> tick every 7 clk; clk_out high 3.5 clk, low 3.5 clk; first rise at first enabled posedge.
2. div_load with div_val=4 at cnt=2 of an N=7 period -> div_busy=1; current 7-cycle period completes; then tick every 4 clk, clk_out 2 high/2 low; div_busy=0; div_cur=4.
3. div_load with div_val=1, then div_val=0 -> div_err pulses once each; div_cur, period and div_busy unchanged.
4. N=5 running, en=0 for 10 clk, load 9, en=1 -> clk_out low within 1 clk; div_cur=9 while disabled; restart rise on first enabled posedge, period 9, high 4.5 clk.
5. Two loads (6 then 3) inside one period, with the second landing on the boundary cycle -> 6 applied at the boundary, 3 applied one period of 6 later; no glitch at either switch.
6. rst asserted mid-high phase with N=255 pending -> clk_out=0 and div_busy=0 after 1 clk; div_cur=7 after release.

Source files
------------

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with 50% duty for odd and even ratios.
// Ratio changes land on period boundaries; one negedge flop supplies the half-cycle for odd ratios.
module clk_div_prog #(
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
  output logic             div_busy,
  output logic             div_err,
  output logic [CNT_W-1:0] div_cur,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [CNT_W-1:0] DEF     = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(2);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] pending;
  logic [CNT_W-1:0] last;
  logic [CNT_W-1:0] cur_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             div_p;
  logic             div_n;
  logic             at_end;
  logic             apply;
  logic             load_ok;

  function automatic logic [CNT_W-1:0] half(input logic [CNT_W-1:0] n);
    return n >> 1;
  endfunction

  always_comb begin
    last    = div_cur - ONE;
    at_end  = (cnt == last);
    apply   = div_busy && (!en || at_end);
    cur_nxt = apply ? pending : div_cur;
    cnt_nxt = at_end ? '0 : cnt + ONE;
    load_ok = div_load && (div_val >= MIN_DIV);
  end

  // Posedge stage: period counter, high-phase flag, tick and ratio handshake.
  // An apply with en=1 always coincides with at_end, so cnt_nxt is already 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cur  <= DEF;
      cnt      <= DEF - ONE;
      pending  <= '0;
      div_p    <= 1'b0;
      tick     <= 1'b0;
      div_busy <= 1'b0;
      div_err  <= 1'b0;
    end else begin
      div_err <= div_load && (div_val < MIN_DIV);
      div_cur <= cur_nxt;
      if (en) begin
        cnt   <= cnt_nxt;
        div_p <= (cnt_nxt < half(cur_nxt));
        tick  <= (cnt_nxt == '0);
      end else begin
        cnt   <= cur_nxt - ONE;
        div_p <= 1'b0;
        tick  <= 1'b0;
      end
      if (load_ok) begin
        pending  <= div_val;
        div_busy <= 1'b1;
      end else if (apply) begin
        div_busy <= 1'b0;
      end
    end
  end

  // Negedge stage: half-period delayed copy of div_p for odd-ratio stretching.
  always_ff @(negedge clk) begin
    if (rst) div_n <= 1'b0;
    else     div_n <= div_p;
  end

  // Gating by the current parity means a stale div_n after an odd-to-even switch is ignored.
  assign clk_out = div_cur[0] ? (div_p | div_n) : div_p;

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: directed scenarios plus randomized traffic against a period/phase model.
module tb_clk_div_prog;
  localparam int CNT_W   = 8;
  localparam int DEF_DIV = 7;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             div_load = 1'b0;
  logic [CNT_W-1:0] div_val = '0;
  logic             div_busy;
  logic             div_err;
  logic [CNT_W-1:0] div_cur;
  logic             clk_out;
  logic             tick;

  clk_div_prog #(.CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) dut (
    .clk(clk), .rst(rst), .en(en), .div_val(div_val), .div_load(div_load),
    .div_busy(div_busy), .div_err(div_err), .div_cur(div_cur),
    .clk_out(clk_out), .tick(tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: position m_p inside the current period of length m_cur.
  int m_cur = DEF_DIV, m_pend = 0, m_p = 0;
  bit m_busy = 0, m_err = 0, m_parked = 1, m_hp = 0, m_hp_prev = 0, m_tk = 0;
  bit chk_out = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit e, input bit ld, input int v);
    bit boundary, apply;
    rst = r; en = e; div_load = ld; div_val = v[CNT_W-1:0];
    @(posedge clk);
    m_hp_prev = m_hp;
    if (r) begin
      m_cur = DEF_DIV; m_pend = 0; m_busy = 0; m_err = 0;
      m_parked = 1; m_hp = 0; m_tk = 0;
    end else begin
      m_err    = ld && (v < 2);
      boundary = m_parked || (m_p == m_cur - 1);
      apply    = m_busy && (!e || boundary);
      if (apply) m_cur = m_pend;
      if (e) begin
        m_p = boundary ? 0 : m_p + 1;
        m_parked = 0;
      end else begin
        m_parked = 1;
      end
      m_hp = e && (m_p < m_cur / 2);
      m_tk = e && (m_p == 0);
      if (ld && v >= 2) begin
        m_pend = v; m_busy = 1;
      end else if (apply) begin
        m_busy = 0;
      end
    end
    #1;
    check("tick", tick, m_tk);
    check("div_cur", div_cur, m_cur);
    check("div_busy", div_busy, m_busy);
    check("div_err", div_err, m_err);
    // Just after posedge an odd ratio still shows the previous high level via the negedge copy.
    if (chk_out) check("clk_out_pos", clk_out, m_hp | ((m_cur % 2 == 1) & m_hp_prev));
    chk_out = 1;
    @(negedge clk);
    #1;
    check("clk_out_neg", clk_out, m_hp);
  endtask

  task automatic measure_period(output int n);
    int i;
    i = 0;
    while (!tick && i < 600) begin step(0, 1, 0, 0); i++; end
    check("tick_wait", tick, 1'b1);
    n = 0;
    do begin step(0, 1, 0, 0); n++; end while (!tick && n < 600);
  endtask

  initial begin
    int n, i;
    // Reset
    for (i = 0; i < 3; i++) step(1, 0, 0, 0);
    check("rst_cur", div_cur, DEF_DIV);
    check("rst_clk_out", clk_out, 1'b0);
    check("rst_busy", div_busy, 1'b0);

    // Default ratio, first rise on first enabled posedge
    step(0, 1, 0, 0);
    check("first_rise", clk_out, 1'b1);
    check("first_tick", tick, 1'b1);
    measure_period(n);
    check("period7", n, 7);

    // Load 4 at cnt=2
    for (i = 0; i < 20 && m_p != 2; i++) step(0, 1, 0, 0);
    step(0, 1, 1, 4);
    check("busy_after_load", div_busy, 1'b1);
    for (i = 0; i < 10; i++) step(0, 1, 0, 0);
    check("cur4", div_cur, 4);
    measure_period(n);
    check("period4", n, 4);

    // Illegal ratios
    step(0, 1, 1, 1);
    check("err_val1", div_err, 1'b1);
    step(0, 1, 1, 0);
    check("err_val0", div_err, 1'b1);
    step(0, 1, 0, 0);
    check("err_clear", div_err, 1'b0);
    measure_period(n);
    check("period4_kept", n, 4);

    // N=5, disable, load 9 while disabled, re-enable
    step(0, 1, 1, 5);
    for (i = 0; i < 12; i++) step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    check("park_low", clk_out, 1'b0);
    for (i = 0; i < 4; i++) step(0, 0, 0, 0);
    step(0, 0, 1, 9);
    for (i = 0; i < 4; i++) step(0, 0, 0, 0);
    check("cur9_disabled", div_cur, 9);
    step(0, 1, 0, 0);
    check("restart_rise", clk_out, 1'b1);
    measure_period(n);
    check("period9", n, 9);

    // Two loads in one period, second on the boundary cycle
    for (i = 0; i < 20 && m_p != 0; i++) step(0, 1, 0, 0);
    step(0, 1, 1, 6);
    for (i = 0; i < 20 && m_p != m_cur - 1; i++) step(0, 1, 0, 0);
    step(0, 1, 1, 3);
    check("cur6_applied", div_cur, 6);
    check("busy_3_pending", div_busy, 1'b1);
    for (i = 0; i < 6; i++) step(0, 1, 0, 0);
    check("cur3_applied", div_cur, 3);
    measure_period(n);
    check("period3", n, 3);

    // Reset mid-high phase with 255 pending
    for (i = 0; i < 20 && m_p != m_cur - 1; i++) step(0, 1, 0, 0);
    step(0, 1, 1, 255);
    check("high_before_rst", clk_out, 1'b1);
    step(1, 1, 0, 0);
    check("rst_busy_clr", div_busy, 1'b0);
    check("rst_low", clk_out, 1'b0);
    step(0, 1, 0, 0);
    check("cur7_after_rst", div_cur, DEF_DIV);

    // Randomized traffic
    for (i = 0; i < 3000; i++) begin
      bit r, e, ld;
      int v;
      r  = ($urandom_range(0, 299) == 0);
      e  = ($urandom_range(0, 9) != 0);
      ld = ($urandom_range(0, 14) == 0);
      case ($urandom_range(0, 19))
        0, 1, 2, 3, 4: v = $urandom_range(0, 3);
        5:             v = 255;
        default:       v = $urandom_range(2, 20);
      endcase
      step(r, e, ld, v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
